// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debounce path.
// The optional auto-repeat feature is enabled with the BTN_AUTOREPEAT_EN macro.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_REPEAT_DELAY  = 16;
    localparam int unsigned DEF_REPEAT_PERIOD = 8;

    // One counter width covers stable, delay and period counts so none can wrap.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset; q_o is the second flop.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button debouncer: synchronise, stable-count filter, one-cycle press strobe and debounced level.
// Define BTN_AUTOREPEAT_EN to add auto-repeat strobes while the button stays pressed.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out,
    output logic level_out,
    output logic busy
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             rpt_fire;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered alongside it.
    always_comb begin
        pulse_d = ((state_q == PRESS_WAIT) && (state_d == PRESSED)) || rpt_fire;
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;

    // Phase 0 counts the initial delay, phase 1 the repeat period; anything but staying in PRESSED clears both.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
        rpt_fire    = 1'b0;
        if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            rpt_phase_d = rpt_phase_q;
            if (rpt_cnt_q == (rpt_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign pulse_out = pulse_q;
    assign level_out = level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse: vector table, corner-case sequences, random bursts vs a run-length model.
// Honours BTN_AUTOREPEAT_EN the same way as the design.
module tb_btn_debounce_pulse;

    localparam int S = 4;
    localparam int D = 16;
    localparam int P = 8;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pulse_out;
    logic level_out;
    logic busy;

    btn_debounce_pulse #(
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .pulse_out (pulse_out),
        .level_out (level_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_no      = 0;

    // Reference model: debounced level flips once S+1 consecutive synchronised samples disagree with it.
    logic m_sh0, m_sh1;
    logic m_level;
    int   m_run;
    int   m_age;
    logic m_pulse;
    logic m_busy;

    function void check(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at edge %0d: got %0b, expected %0b", name, edge_no, act, exp);
        end
    endfunction

    function void model_step(input logic b, input logic r);
        logic s;
        logic was_pressed;
        if (r) begin
            m_sh0 = 1'b0; m_sh1 = 1'b0; m_level = 1'b0;
            m_run = 0; m_age = 0; m_pulse = 1'b0; m_busy = 1'b0;
        end else begin
            s = m_sh1;
            m_sh1 = m_sh0;
            m_sh0 = b;
            m_pulse = 1'b0;
            was_pressed = m_level && (m_run == 0);
            if (s != m_level) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_level = s;
                    m_run   = 0;
                    if (s) m_pulse = 1'b1;
                end
            end else begin
                m_run = 0;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (m_level && (m_run == 0)) begin
                m_age = was_pressed ? m_age + 1 : 0;
                if (was_pressed && m_age >= D && ((m_age - D) % P) == 0) m_pulse = 1'b1;
            end else begin
                m_age = 0;
            end
`else
            m_age = was_pressed ? m_age + 1 : 0;
`endif
            m_busy = (m_run != 0);
        end
    endfunction

    task automatic tick(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        edge_no++;
        model_step(b, r);
        #1;
        check("model_pulse", pulse_out, m_pulse);
        check("model_level", level_out, m_level);
        check("model_busy", busy, m_busy);
    endtask

    typedef struct {
        logic btn;
        logic exp_pulse;
        logic exp_level;
        logic exp_busy;
    } vec_t;

    localparam int K = 4;
    localparam int R = K + S + 6;
    localparam int NV = R + S + 4;
    vec_t tbl [NV];

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int pulses;

    initial begin
        btn_in = 1'b0;
        reset  = 1'b1;

        // Clean press at index K, clean release at index R; expectations written from the timing rules.
        for (int i = 0; i < NV; i++) begin
            tbl[i].btn       = (i >= K) && (i < R);
            tbl[i].exp_pulse = (i == K + S + 2);
            tbl[i].exp_level = (i >= K + S + 2) && (i < R + S + 2);
            tbl[i].exp_busy  = ((i >= K + 2) && (i <= K + S + 1)) || ((i >= R + 2) && (i <= R + S + 1));
        end

        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("reset_pulse", pulse_out, 1'b0);
        check("reset_level", level_out, 1'b0);
        check("reset_busy", busy, 1'b0);

        for (int i = 0; i < NV; i++) begin
            tick(tbl[i].btn, 1'b0);
            check("tbl_pulse", pulse_out, tbl[i].exp_pulse);
            check("tbl_level", level_out, tbl[i].exp_level);
            check("tbl_busy", busy, tbl[i].exp_busy);
        end

        // Bounce: 3 high, 2 low, then held; one pulse S+2 edges after the final rising sample.
        for (int j = 0; j < 3; j++) tick(1'b1, 1'b0);
        for (int j = 0; j < 2; j++) begin
            tick(1'b0, 1'b0);
            check("glitch_pulse", pulse_out, 1'b0);
            check("glitch_level", level_out, 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            tick(1'b1, 1'b0);
            check("glitch_pulse", pulse_out, 1'b0);
        end
        pulses = 0;
        for (int j = 0; j < 200; j++) begin
            tick(1'b1, 1'b0);
            if (pulse_out) pulses++;
            if (j < 10) check("bounce_pulse_time", pulse_out, (j == S - 1));
        end
`ifndef BTN_AUTOREPEAT_EN
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL long_hold_pulses: got %0d, expected 1", pulses);
        end
`endif
        // Clean release after the long hold.
        for (int j = 0; j < 10; j++) begin
            tick(1'b0, 1'b0);
            check("release_level", level_out, (j < S + 2));
        end

        // Release bounce: brief return to 1 during RELEASE_WAIT.
        for (int j = 0; j < S + 4; j++) tick(1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick(1'b0, 1'b0);
            check("rel_bounce_level", level_out, 1'b1);
        end
        for (int j = 0; j < 10; j++) begin
            tick(1'b1, 1'b0);
            check("rel_bounce_pulse", pulse_out, 1'b0);
            check("rel_bounce_level", level_out, 1'b1);
        end
        for (int j = 0; j < S + 6; j++) tick(1'b0, 1'b0);
        check("idle_level", level_out, 1'b0);

        // Reset while PRESS_WAIT has counted to 2, button kept high throughout.
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b0);
        check("pre_reset_busy", busy, 1'b1);
        tick(1'b1, 1'b1);
        check("mid_reset_pulse", pulse_out, 1'b0);
        check("mid_reset_level", level_out, 1'b0);
        check("mid_reset_busy", busy, 1'b0);
        for (int j = 0; j < S + 5; j++) begin
            tick(1'b1, 1'b0);
            check("post_reset_pulse", pulse_out, (j == S + 2));
            check("post_reset_level", level_out, (j >= S + 2));
        end
        for (int j = 0; j < S + 6; j++) tick(1'b0, 1'b0);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat: pulses at t0, t0+D, then every P while held; none after release.
        exp_q = {};
        got_q = {};
        exp_q.push_back(8'(S + 2));
        for (int t = S + 2 + D; t <= S + 2 + 48; t += P) exp_q.push_back(8'(t));
        for (int j = 0; j < S + 2 + 50; j++) begin
            tick(1'b1, 1'b0);
            if (pulse_out) got_q.push_back(8'(j));
        end
        for (int j = 0; j < 20; j++) begin
            tick(1'b0, 1'b0);
            if (pulse_out) got_q.push_back(8'(S + 2 + 50 + j));
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL repeat_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] != exp_q[i]) begin
                tests_failed++;
                $display("FAIL repeat_time[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
            end
        end
`endif

        // Random bursts with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * S + 3);
            if ($urandom_range(0, 60) == 0) tick(b, 1'b1);
            for (int j = 0; j < len; j++) tick(b, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
